// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between a host controller and the PS/2 transmitter
interface ps2_host_tx_if;
    logic [7:0] data_in;
    logic       strobe_in;
    logic       busy;
    logic       done;
    logic       error;

    // Controller side: issues command bytes and watches completion.
    modport master (
        output data_in,
        output strobe_in,
        input  busy,
        input  done,
        input  error
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  strobe_in,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ack)
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 800,
    parameter int TIMEOUT_TICKS = 16000
) (
    input  logic         clk,
    input  logic         _reset,
    input  logic         cep,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int MAX_TICKS = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
    localparam int TW = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        RELEASE
    } txState_t;

    txState_t        state;
    txState_t        stateNext;

    logic [1:0]      clkSync;
    logic [1:0]      datSync;
    logic            clkPrev;
    logic            fallEdge;
    logic            lineClk;
    logic            lineDat;

    logic [TW-1:0]   tickCount;
    logic [3:0]      bitCount;
    // Frame still to be driven, LSB first: {stop, parity, d7..d0}.
    logic [9:0]      shiftReg;

    logic            clkOe;
    logic            datOe;
    logic            doneReg;
    logic            errorReg;

    logic            clkOeNext;
    logic            datOeNext;
    logic            doneNext;
    logic            errorNext;
    logic            loadFrame;
    logic            shiftStep;
    logic            tickClear;
    logic            tickRun;
    logic            timeoutHit;

    assign lineClk    = clkSync[1];
    assign lineDat    = datSync[1];
    assign fallEdge   = clkPrev & ~lineClk;
    // A falling edge restarts the timeout window, so it takes priority over expiry.
    assign timeoutHit = cep && !fallEdge && (tickCount == TIMEOUT_LAST);

    assign host.busy  = (state != IDLE);
    assign host.done  = doneReg;
    assign host.error = errorReg;
    assign ps2_clk_oe = clkOe;
    assign ps2_dat_oe = datOe;

    // Bring the raw open-drain lines into the clk domain and remember the last clock level.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            clkSync <= 2'b11;
            datSync <= 2'b11;
            clkPrev <= 1'b1;
        end else begin
            clkSync <= {clkSync[0], ps2_clk_in};
            datSync <= {datSync[0], ps2_dat_in};
            clkPrev <= lineClk;
        end
    end

    // State register plus registered line drivers and status pulses.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state    <= IDLE;
            clkOe    <= 1'b0;
            datOe    <= 1'b0;
            doneReg  <= 1'b0;
            errorReg <= 1'b0;
        end else begin
            state    <= stateNext;
            clkOe    <= clkOeNext;
            datOe    <= datOeNext;
            doneReg  <= doneNext;
            errorReg <= errorNext;
        end
    end

    // Tick counter (inhibit length, then inter-edge timeout), bit counter and frame shifter.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            tickCount <= '0;
            bitCount  <= 4'd0;
            shiftReg  <= 10'd0;
        end else begin
            if (tickClear) begin
                tickCount <= '0;
            end else if (tickRun && cep) begin
                tickCount <= tickCount + TW'(1);
            end
            if (loadFrame) begin
                shiftReg <= {1'b1, ~^host.data_in, host.data_in};
                bitCount <= 4'd0;
            end else if (shiftStep) begin
                shiftReg <= {1'b1, shiftReg[9:1]};
                bitCount <= bitCount + 4'd1;
            end
        end
    end

    // Next-state and next-output decode for the frame sequence.
    always_comb begin
        stateNext = state;
        clkOeNext = 1'b0;
        datOeNext = 1'b0;
        doneNext  = 1'b0;
        errorNext = 1'b0;
        loadFrame = 1'b0;
        shiftStep = 1'b0;
        tickClear = 1'b0;
        tickRun   = 1'b0;
        case (state)
            IDLE: begin
                if (host.strobe_in) begin
                    loadFrame = 1'b1;
                    tickClear = 1'b1;
                    clkOeNext = 1'b1;
                    stateNext = INHIBIT;
                end
            end
            INHIBIT: begin
                clkOeNext = 1'b1;
                tickRun   = 1'b1;
                if (cep && (tickCount == INHIBIT_LAST)) begin
                    clkOeNext = 1'b0;
                    datOeNext = 1'b1;
                    tickClear = 1'b1;
                    stateNext = RTS;
                end
            end
            RTS: begin
                // Start bit is already on the line; the device starts clocking once it sees it.
                datOeNext = 1'b1;
                tickRun   = 1'b1;
                tickClear = fallEdge;
                if (timeoutHit) begin
                    datOeNext = 1'b0;
                    errorNext = 1'b1;
                    stateNext = IDLE;
                end else if (cep) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                datOeNext = datOe;
                tickRun   = 1'b1;
                tickClear = fallEdge;
                if (fallEdge) begin
                    shiftStep = 1'b1;
                    datOeNext = ~shiftReg[0];
                    // Tenth edge puts the stop bit (released line) out.
                    if (bitCount == 4'd9) begin
                        stateNext = ACK;
                    end
                end else if (timeoutHit) begin
                    datOeNext = 1'b0;
                    errorNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            ACK: begin
                tickRun   = 1'b1;
                tickClear = fallEdge;
                if (fallEdge) begin
                    if (lineDat) begin
                        errorNext = 1'b1;
                    end else begin
                        doneNext = 1'b1;
                    end
                    stateNext = RELEASE;
                end else if (timeoutHit) begin
                    errorNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            RELEASE: begin
                tickRun   = 1'b1;
                tickClear = fallEdge;
                if (lineClk && lineDat) begin
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    errorNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end
endmodule
